sbp_lookup_tail: RTL
====================

// Module: sbp_lookup_tail
// PURPOSE
//  Tail of the lookup pipeline; consumes the token leaving the last sbp_lookup_stage.
//  Captures {ip_addr, result} into a result FIFO and presents it on a valid/ready port.
//  The stage chain cannot stall, so the block also issues credits to the request injector.
//  An injection is allowed only while a FIFO slot is guaranteed for its result.
// PARAMETERS
//  STAGE_ID_BITS   6   width of stage id field in result
//  LOCATION_BITS   11  width of location field in result
//  FIFO_DEPTH      16  result FIFO entries; power of 2, >= 2
//  CNT_BITS        $clog2(FIFO_DEPTH)+1  occupancy/inflight counter width (derived, localparam)
// PORTS
//  clk          in   1    clock, all logic on posedge
//  rst          in   1    asynchronous, active-low reset (rst==0 resets)
//  issue_i      in   1    injector pushed one lookup into stage 1 this cycle
//  issue_ok_o   out  1    credit available; injector may assert issue_i this cycle
//  valid_i      in   1    token from last stage is valid this cycle
//  ip_addr_i    in   32   ip_addr_o of last stage
//  result_i     in   STAGE_ID_BITS+LOCATION_BITS  result_o of last stage
//  res_valid_o  out  1    FIFO head valid
//  res_ready_i  in   1    consumer accepts head
//  res_ip_addr_o out 32   head ip address
//  res_result_o out  STAGE_ID_BITS+LOCATION_BITS  head {stage_id, location} of longest match
//  res_hit_o    out  1    head result != 0 (stage ids start at 1, so 0 == no match)
//  inflight_o   out  CNT_BITS  lookups issued but not yet arrived
//  occupancy_o  out  CNT_BITS  FIFO entries held
//  overflow_o   out  1    sticky: valid_i dropped because FIFO full
//  proto_err_o  out  1    sticky: issue_i without credit, or valid_i with inflight==0
// BEHAVIOUR
//  Reset: pointers, inflight, occupancy = 0; res_valid_o=0; issue_ok_o=1; overflow_o=0; proto_err_o=0.
//   FIFO storage is not reset.
//  Push = valid_i && (!full || pop). Pop = res_valid_o && res_ready_i.
//  Push and pop in one cycle at full: both happen; occupancy stays FIFO_DEPTH, no overflow.
//  FIFO is first-word-fall-through from a register array.
//   valid_i at cycle N -> res_valid_o=1 at N+1 (1-cycle latency into an empty FIFO).
//   res_* are driven from mem[rd_ptr]; they are stable while res_valid_o && !res_ready_i.
//  Pointers are CNT_BITS wide; the MSB is the wrap bit.
//   empty: rd==wr. full: low bits equal and wrap bits differ.
//   Pointers wrap modulo 2*FIFO_DEPTH with no special case.
//  valid_i while full && !pop: token dropped; overflow_o set until reset.
//   A drop still decrements inflight.
//  Credit: issue_ok_o = (occupancy + inflight) < FIFO_DEPTH, combinational from registers only.
//   It has no combinational path from issue_i, valid_i or res_ready_i.
//  inflight next = inflight + (issue_i && issue_ok_o) - (valid_i && inflight!=0).
//   Simultaneous issue and arrival leave inflight unchanged.
//  issue_i while !issue_ok_o: not counted; proto_err_o set.
//  valid_i while inflight==0: inflight held at 0; proto_err_o set; token still pushed if there is space.
//  Counters never wrap. Under correct protocol, occupancy+inflight <= FIFO_DEPTH always.
//  Reset asserted mid-operation clears all state at once; queued results are discarded.
//   Tokens still in the stage chain then arrive as proto errors.
//   The injector must also be reset, and the chain flushed, by the same reset.
// STRUCTURE
//  sbp_pkg: localparam RESULT_BITS = STAGE_ID_BITS+LOCATION_BITS.
//  sbp_pkg: typedef struct packed { logic [31:0] ip_addr; logic [RESULT_BITS-1:0] result; } sbp_result_t.
//  sbp_pkg: NO_MATCH = '0.
//  Sub-module sbp_sync_fifo #(WIDTH, DEPTH): FWFT FIFO with push/pop/full/empty/count.
//  Credit counters, sticky flags and hit decode stay in sbp_lookup_tail.
// TESTING
//  1 Reset, then issue_i one cycle and valid_i 3 cycles later with ip=0x0A000001, result=0x0805.
//    -> res_valid_o=1 one cycle after valid_i, res_hit_o=1, inflight_o back to 0.
//  2 res_ready_i=0; issue FIFO_DEPTH=16 lookups, all arrive.
//    -> issue_ok_o=0 after the 16th issue; occupancy_o=16; results in order.
//    -> one pop re-raises issue_ok_o next cycle.
//  3 FIFO full, valid_i and res_ready_i in the same cycle.
//    -> occupancy stays 16; new entry lands at the tail; overflow_o=0.
//  4 FIFO full, res_ready_i=0, forced valid_i.
//    -> entry dropped; overflow_o=1 and sticky; proto_err_o=1 if no credit was issued.
//  5 result_i=0 -> res_hit_o=0.
//    Run 40 push/pop cycles with random res_ready_i -> pointer wrap; data order matches the scoreboard.
//  6 rst=0 asynchronously, mid-burst, between clock edges.
//    -> res_valid_o=0 and issue_ok_o=1 immediately; counters 0; sticky flags cleared.

Source files
------------

// File: rtl/sbp_pkg.sv
// Shared widths and result record for the lookup pipeline tail.
// The stage chain, the tail and the bench all agree on this layout.
package sbp_pkg;

  localparam int STAGE_ID_BITS = 6;
  localparam int LOCATION_BITS = 11;
  localparam int RESULT_BITS   = STAGE_ID_BITS + LOCATION_BITS;
  localparam int FIFO_DEPTH    = 16;
  localparam int CNT_BITS      = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [31:0]            ip_addr;
    logic [RESULT_BITS-1:0] result;
  } sbp_result_t;

  // Stage ids start at 1, so an all-zero result means no prefix matched.
  localparam logic [RESULT_BITS-1:0] NO_MATCH = '0;

endpackage

// File: rtl/sbp_lookup_tail_if.sv
// Credit, token and result-port signals of the lookup tail.
// slave is the tail itself; master is the injector/chain/consumer side.
interface sbp_lookup_tail_if #(
  parameter int RESULT_BITS = sbp_pkg::RESULT_BITS,
  parameter int CNT_BITS    = sbp_pkg::CNT_BITS
);

  logic                   issue_i;
  logic                   issue_ok_o;
  logic                   valid_i;
  logic [31:0]            ip_addr_i;
  logic [RESULT_BITS-1:0] result_i;
  logic                   res_valid_o;
  logic                   res_ready_i;
  logic [31:0]            res_ip_addr_o;
  logic [RESULT_BITS-1:0] res_result_o;
  logic                   res_hit_o;
  logic [CNT_BITS-1:0]    inflight_o;
  logic [CNT_BITS-1:0]    occupancy_o;
  logic                   overflow_o;
  logic                   proto_err_o;

  modport slave (
    input  issue_i, valid_i, ip_addr_i, result_i, res_ready_i,
    output issue_ok_o, res_valid_o, res_ip_addr_o, res_result_o, res_hit_o,
           inflight_o, occupancy_o, overflow_o, proto_err_o
  );

  modport master (
    output issue_i, valid_i, ip_addr_i, result_i, res_ready_i,
    input  issue_ok_o, res_valid_o, res_ip_addr_o, res_result_o, res_hit_o,
           inflight_o, occupancy_o, overflow_o, proto_err_o
  );

endinterface

// File: rtl/sbp_sync_fifo.sv
// First-word-fall-through FIFO over a register array; the head is read
// combinationally from mem[rd_ptr]. Pointer MSB is the wrap bit.
module sbp_sync_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [WIDTH-1:0]        i_wdata,
  output logic [WIDTH-1:0]        o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide what
  // is valid, and leaving the array reset-free keeps it plain flops/RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/sbp_lookup_tail.sv
// Tail of the lookup pipeline: buffers {ip_addr, result} tokens from the last
// stage and hands out injection credits so results always find a FIFO slot.
module sbp_lookup_tail #(
  parameter int STAGE_ID_BITS = sbp_pkg::STAGE_ID_BITS,
  parameter int LOCATION_BITS = sbp_pkg::LOCATION_BITS,
  parameter int FIFO_DEPTH    = sbp_pkg::FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  sbp_lookup_tail_if.slave    bus
);

  localparam int RES_W    = STAGE_ID_BITS + LOCATION_BITS;
  localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;
  localparam int WIDTH    = 32 + RES_W;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_credit;
  logic                w_issue;
  logic                w_arrive;
  logic [CNT_BITS-1:0] w_count;
  logic [CNT_BITS:0]   w_committed;
  logic [WIDTH-1:0]    w_wdata;
  logic [WIDTH-1:0]    w_rdata;
  logic [CNT_BITS-1:0] r_inflight;
  logic                r_overflow;
  logic                r_proto_err;

  assign w_pop  = !w_empty && bus.res_ready_i;
  assign w_push = bus.valid_i && (!w_full || w_pop);
  assign w_drop = bus.valid_i && w_full && !w_pop;

  // Credit looks only at registered counts, never at this cycle's inputs.
  assign w_committed = {1'b0, w_count} + {1'b0, r_inflight};
  assign w_credit    = w_committed < (CNT_BITS+1)'(FIFO_DEPTH);
  assign w_issue     = bus.issue_i && w_credit;
  assign w_arrive    = bus.valid_i && (r_inflight != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_arrive})
        2'b10:   r_inflight <= r_inflight + CNT_BITS'(1);
        2'b01:   r_inflight <= r_inflight - CNT_BITS'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if ((bus.issue_i && !w_credit) || (bus.valid_i && r_inflight == '0))
        r_proto_err <= 1'b1;
    end
  end

  assign w_wdata = {bus.ip_addr_i, bus.result_i};

  sbp_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.issue_ok_o    = w_credit;
  assign bus.res_valid_o   = !w_empty;
  assign bus.res_ip_addr_o = w_rdata[RES_W +: 32];
  assign bus.res_result_o  = w_rdata[RES_W-1:0];
  assign bus.res_hit_o     = |w_rdata[RES_W-1:0];
  assign bus.inflight_o    = r_inflight;
  assign bus.occupancy_o   = w_count;
  assign bus.overflow_o    = r_overflow;
  assign bus.proto_err_o   = r_proto_err;

endmodule
